mem_responder: RTL and testbench

- Memory-side responder for the multicycle CPU's load/store traffic; it is the target end of the CPU's memory requests.
- Accepts one request at a time: word, halfword or byte; read or write.
- Owns a word-organised, little-endian, byte-addressed storage array.
- Performs read-modify-write (RMW) for sub-word stores and returns a single-cycle response pulse that the CPU control FSM waits on.

---
 rtl/mem_pkg.sv | 48 ++++
 rtl/word_ram.sv | 26 ++
 rtl/mem_responder.sv | 128 ++++++++++++
 tb/tb_mem_responder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and lane helpers for the memory responder.
// Lanes are little-endian: byte lane n is bits [8n+7:8n] of the word.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    MERGE   = 3'd2,
    WR      = 3'd3,
    RESP    = 3'd4
  } state_e;

  // Replace the addressed lane of word with the right-aligned store data.
  function automatic logic [31:0] lane_merge(input logic [31:0] word,
                                             input logic [31:0] wdata,
                                             input size_e       size,
                                             input logic [1:0]  lane);
    logic [31:0] res;
    res = word;
    case (size)
      SZ_BYTE: res[{lane, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: res[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Pull the addressed lane out of word, zero-extended.
  function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                               input size_e       size,
                                               input logic [1:0]  lane);
    logic [31:0] res;
    case (size)
      SZ_BYTE: res = {24'h0, word[{lane, 3'b000} +: 8]};
      SZ_HALF: res = {16'h0, word[{lane[1], 4'b0000} +: 16]};
      default: res = word;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/word_ram.sv
// Word storage with a WAIT_CYCLES-deep read pipeline and one write port.
// Contents are never reset; rd_data reflects mem[rd_idx] sampled WAIT_CYCLES edges ago.
module word_ram #(
  parameter int IDX_W       = 6,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [31:0]      wr_data
);

  logic [31:0] mem  [2**IDX_W];
  logic [31:0] pipe [WAIT_CYCLES];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
    pipe[0] <= mem[rd_idx];
    for (int i = 1; i < WAIT_CYCLES; i++) pipe[i] <= pipe[i-1];
  end

  assign rd_data = pipe[WAIT_CYCLES-1];

endmodule

// File: rtl/mem_responder.sv
// Target end of the CPU load/store path: one request at a time, RMW for sub-word
// stores, single-cycle registered response pulse.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [2:0]  fsm_state
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  // Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // req_ready is high only in IDLE. rsp_valid is a one-cycle pulse with no backpressure.
  state_e              state, state_next;
  logic [3:0]          wait_cnt;
  logic                wr_q;
  size_e               size_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic                accept, req_err;
  logic [31:0]         rd_data;
  logic                ram_wr_en;
  logic [31:0]         ram_wr_data;
  logic [IDX_W-1:0]    rd_idx;
  logic                unused_addr_hi;

  assign accept = req_valid && req_ready;
  assign req_err = (req_size == SZ_RSVD) ||
                   (req_size == SZ_HALF && req_addr[0]) ||
                   (req_size == SZ_WORD && req_addr[1:0] != 2'b00);
  assign unused_addr_hi = ^req_addr[31:ADDR_W];

  // Start the read at acceptance so the word is ready after WAIT_CYCLES edges.
  assign rd_idx = (state == IDLE) ? req_addr[ADDR_W-1:2] : addr_q[ADDR_W-1:2];
  assign fsm_state = state;

  word_ram #(.IDX_W(IDX_W), .WAIT_CYCLES(WAIT_CYCLES)) u_ram (
    .clk     (Clk),
    .rd_idx  (rd_idx),
    .rd_data (rd_data),
    .wr_en   (ram_wr_en),
    .wr_idx  (addr_q[ADDR_W-1:2]),
    .wr_data (ram_wr_data)
  );

  always_comb begin
    state_next  = state;
    ram_wr_en   = 1'b0;
    ram_wr_data = wdata_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                   state_next = RESP;
          else if (!req_wr)              state_next = RD_WAIT;
          else if (req_size == SZ_WORD)  state_next = WR;
          else                           state_next = RD_WAIT;
        end
      end
      RD_WAIT: if (wait_cnt == LAST_WAIT) state_next = wr_q ? MERGE : RESP;
      MERGE: begin
        ram_wr_en   = 1'b1;
        ram_wr_data = lane_merge(rd_data, wdata_q, size_q, addr_q[1:0]);
        state_next  = RESP;
      end
      WR: begin
        ram_wr_en  = 1'b1;
        state_next = RESP;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      wait_cnt  <= 4'd0;
      wr_q      <= 1'b0;
      size_q    <= SZ_WORD;
      addr_q    <= '0;
      wdata_q   <= 32'h0;
    end else begin
      state     <= state_next;
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (state == IDLE && accept) begin
        wr_q    <= req_wr;
        size_q  <= size_e'(req_size);
        addr_q  <= req_addr[ADDR_W-1:0];
        wdata_q <= req_wdata;
      end
      if (state == RD_WAIT && wait_cnt != LAST_WAIT) wait_cnt <= wait_cnt + 4'd1;
      else                                          wait_cnt <= 4'd0;
      // Only the error path goes straight from IDLE to RESP.
      if (state_next == RESP && state != RESP) begin
        if (state == IDLE) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= 32'h0;
        end else if (state == RD_WAIT) begin
          rsp_err   <= 1'b0;
          rsp_rdata <= lane_extract(rd_data, size_q, addr_q[1:0]);
        end else begin
          rsp_err   <= 1'b0;
          rsp_rdata <= 32'h0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder with a queue scoreboard and a
// byte-addressed reference model of the storage.
module tb_mem_responder;

  localparam int ADDR_W = 8;
  localparam int WAIT   = 4;
  localparam int WORDS  = 2**(ADDR_W-2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wr = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [2:0]  fsm_state;

  always #5 clk = ~clk;

  mem_responder #(.ADDR_W(ADDR_W), .WAIT_CYCLES(WAIT)) dut (
    .Clk       (clk),
    .Reset     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_wr    (req_wr),
    .req_size  (req_size),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .fsm_state (fsm_state)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  logic [31:0] model_mem [WORDS];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: storage as an array of words, lanes picked with shifts and masks.
  task automatic model_req(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, output logic [31:0] rdata,
                           output logic err, output int lat);
    int          idx, sh;
    logic [31:0] mask;
    idx  = int'((addr >> 2) % WORDS);
    sh   = (size == 2'd1) ? (addr[1] ? 16 : 0) : 8 * int'(addr[1:0]);
    mask = (size == 2'd1) ? 32'hFFFF : 32'hFF;
    err  = (size == 2'd3) || (size == 2'd1 && addr[0]) || (size == 2'd0 && addr[1:0] != 2'b00);
    rdata = 32'h0;
    if (err) lat = 1;
    else if (!wr) begin
      lat = WAIT + 1;
      rdata = (size == 2'd0) ? model_mem[idx] : ((model_mem[idx] >> sh) & mask);
    end else if (size == 2'd0) begin
      lat = 2;
      model_mem[idx] = wdata;
    end else begin
      lat = WAIT + 2;
      model_mem[idx] = (model_mem[idx] & ~(mask << sh)) | ((wdata & mask) << sh);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                      input logic [31:0] wdata, input bit drop, output int acc_cyc);
    logic [31:0] rd;
    logic        er;
    int          lat, n;
    req_wr = wr; req_size = size; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      check("accept_timeout", {31'b0, req_ready}, 32'h1);
      req_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc;
    if (!drop) begin
      model_req(wr, size, addr, wdata, rd, er, lat);
      exp_q.push_back('{rdata: rd, err: er, cyc: cyc + lat});
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_rsp: got rsp_valid=1 expected none (cycle %0d)", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_cycle", cyc, mon_e.cyc);
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, mon_e.err});
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2;
    logic [31:0] d_rd;
    logic        d_er;
    int          d_lat;
    logic [1:0]  sz;
    logic [31:0] ad;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_ready", {31'b0, req_ready}, 32'h1);
    check("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    check("reset_err", {31'b0, rsp_err}, 32'h0);
    check("reset_state", {29'b0, fsm_state}, 32'h0);

    for (int i = 0; i < WORDS; i++) send(1'b1, 2'd0, i * 4, $urandom, 1'b0, a1);

    // Word store and load
    send(1'b1, 2'd0, 32'h10, 32'hDEADBEEF, 1'b0, a1);
    send(1'b0, 2'd0, 32'h10, 32'h0, 1'b0, a1);

    // Byte RMW
    send(1'b1, 2'd0, 32'h20, 32'h11223344, 1'b0, a1);
    send(1'b1, 2'd2, 32'h22, 32'h555555AA, 1'b0, a1);
    send(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, a1);
    send(1'b0, 2'd2, 32'h22, 32'h0, 1'b0, a1);

    // Half RMW and error cases
    send(1'b1, 2'd0, 32'h20, 32'h11223344, 1'b0, a1);
    send(1'b1, 2'd1, 32'h22, 32'h1234BEEF, 1'b0, a1);
    send(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, a1);
    send(1'b1, 2'd1, 32'h23, 32'h00007777, 1'b0, a1);
    send(1'b0, 2'd0, 32'h20, 32'h0, 1'b0, a1);
    send(1'b0, 2'd0, 32'h21, 32'h0, 1'b0, a1);
    send(1'b1, 2'd3, 32'h24, 32'hFFFFFFFF, 1'b0, a1);
    send(1'b0, 2'd3, 32'h24, 32'h0, 1'b0, a1);

    // Wrap and back-to-back with a held request
    drain();
    send(1'b1, 2'd0, 32'h104, 32'hCAFEF00D, 1'b0, a1);
    check("busy_ready_low", {31'b0, req_ready}, 32'h0);
    send(1'b0, 2'd0, 32'h04, 32'h0, 1'b0, a2);
    check("b2b_accept_cycle", a2, a1 + 3);

    // Reset during RD_WAIT of a byte store drops it
    send(1'b1, 2'd0, 32'h30, 32'h01020304, 1'b0, a1);
    drain();
    send(1'b1, 2'd2, 32'h30, 32'h000000FF, 1'b1, a1);
    rst_n = 1'b0;
    #2;
    check("rst_mid_ready", {31'b0, req_ready}, 32'h1);
    check("rst_mid_state", {29'b0, fsm_state}, 32'h0);
    check("rst_mid_rsp_valid", {31'b0, rsp_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (WAIT + 3) @(negedge clk);
    send(1'b0, 2'd0, 32'h30, 32'h0, 1'b0, a1);
    drain();

    // Reset just after the WR commit edge keeps the new word
    send(1'b1, 2'd0, 32'h34, 32'h5A5AA5A5, 1'b1, a1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    model_req(1'b1, 2'd0, 32'h34, 32'h5A5AA5A5, d_rd, d_er, d_lat);
    @(negedge clk);
    check("rst_commit_state", {29'b0, fsm_state}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 2'd0, 32'h34, 32'h0, 1'b0, a1);

    // Random mix, mostly aligned, with wrapping addresses
    for (int i = 0; i < 200; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd0) ad[1:0] = 2'b00;
        else if (sz == 2'd1) ad[0] = 1'b0;
      end
      send(1'($urandom_range(0, 1)), sz, ad, $urandom, 1'b0, a1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    drain();
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
